fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  MIPS pipeline fetch stage plus IF/ID register, directly upstream of decode and the hazard unit.
//  Holds pcF and issues one request at a time to a variable-latency instruction memory.
//  Buffers one returned instruction while decode is stalled.
//  Applies stallF/stallD from the hazard unit and branch/jump redirects resolved in D.
//  Inserts NOP bubbles when memory is slow or after a redirect (no delay slot).
// PARAMETERS
//  RESET_PC   32'h0000_0000  pcF value on reset
//  NOP_INSTR  32'h0000_0000  encoding loaded into instrD for a bubble (sll $0,$0,0)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  stallF      in   1   hazard unit: hold PC (equal to stallD in this design)
//  stallD      in   1   hazard unit: hold IF/ID register
//  pcsrcD      in   1   taken branch resolved in D
//  pcbranchD   in   32  branch target
//  jumpD       in   1   jump in D
//  pcjumpD     in   32  jump target
//  imem_req    out  1   request strobe, one cycle per request
//  imem_addr   out  32  request address (word aligned)
//  imem_ready  in   1   response valid, earliest 1 cycle after imem_req
//  imem_rdata  in   32  response instruction
//  instrD      out  32  instruction to decode
//  pcplus4D    out  32  PC+4 of instrD
//  validD      out  1   instrD is a real fetched instruction (0 = bubble)
// BEHAVIOUR
//  Reset: pcF=RESET_PC, FSM=ISSUE, buffer empty, instrD=NOP_INSTR, pcplus4D=0, validD=0.
//  Reset is asynchronous and may assert mid-request. The memory shares reset; imem_ready in ISSUE is ignored.
//  FSM:
//   ISSUE: imem_req=1, imem_addr=pcF, only when buffer empty; -> WAIT. Otherwise stay, imem_req=0.
//   WAIT: on imem_ready the data is "available" this cycle; -> ISSUE.
//   DISCARD: request outstanding but stale; on imem_ready drop data; -> ISSUE.
//  Exactly one outstanding request; imem_req never asserted in WAIT/DISCARD.
//  avail = buffer valid | (WAIT & imem_ready). The buffer has priority over live data; both never coexist.
//  Redirect = ~stallD & (pcsrcD | jumpD). Target: pcbranchD if pcsrcD, else pcjumpD (pcsrcD wins if both).
//  Redirect is ignored while stallD=1 (branch operands unresolved).
//  Per cycle, in priority order:
//   1. Redirect:
//      - pcF<=target, buffer cleared, IF/ID<=bubble (instrD=NOP_INSTR, validD=0).
//      - In WAIT without imem_ready -> DISCARD. In WAIT with imem_ready, the data is dropped -> ISSUE.
//      - Otherwise -> ISSUE. The new request issues the next cycle.
//   2. ~stallD & avail:
//      - instrD<=data, pcplus4D<=pcF+4, validD<=1. Buffer cleared.
//      - If ~stallF then pcF<=pcF+4.
//   3. ~stallD & ~avail: IF/ID<=bubble, pcF held.
//   4. stallD: IF/ID and pcF held. A live response (WAIT & imem_ready) is stored in the buffer, and ISSUE then idles.
//  pcF+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  Throughput: with 1-cycle memory and no stalls, one instruction every 2 cycles (issue, return).
//  Prefetch is outside this block's scope.
// TESTING
//  1. Reset, 1-cycle memory, no stalls:
//     - imem_addr 0,4,8 on cycles 0,2,4.
//     - instrD follows one cycle after each imem_ready with pcplus4D 4,8,12.
//     - Bubbles in between, validD=0.
//  2. Response 0x8C01_0004 arrives while stallD=1 for 3 cycles:
//     - Held in the buffer, no new imem_req.
//     - Delivered to instrD on the first cycle after stallD drops.
//  3. pcsrcD=1, pcbranchD=0x40 while a request is in WAIT (3-cycle memory):
//     - The response is discarded, bubble in D.
//     - The next imem_addr is 0x40, and instrD later shows that data with pcplus4D=0x44.
//  4. pcsrcD=1 with stallD=1: no redirect, pcF unchanged. Redirect takes effect on the first cycle with stallD=0.
//  5. pcsrcD=1 (0x100) and jumpD=1 (0x200) in the same cycle: next imem_addr=0x100.
//  6. reset asserted while in WAIT at pcF=0x20:
//     - All outputs return to reset values immediately.
//     - A stray imem_ready after release is ignored, and the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS fetch stage with IF/ID register.
// Keeps one request in flight to a variable-latency instruction memory and
// holds one returned instruction while decode is stalled. Taken branches and
// jumps resolved in decode redirect the PC and squash the slot with a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc_f;
    logic [XLEN-1:0]   buf_instr;
    logic              buf_valid;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic              live;
    logic              avail;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   pc_plus4;

    // Redirects are only trusted once decode is no longer stalled; branch wins over jump.
    assign redirect = ~stallD & (pcsrcD | jumpD);
    assign target   = pcsrcD ? pcbranchD : pcjumpD;

    // A live response only counts while a real request is outstanding.
    assign live     = (state == S_WAIT) & imem_ready;
    assign avail    = buf_valid | live;
    assign data     = buf_valid ? buf_instr : imem_rdata;
    assign pc_plus4 = pc_f + XLEN'(4);

    // Request is a decode of registered state; it is withheld on a redirect
    // cycle so a stale address never reaches memory.
    assign imem_req  = (state == S_ISSUE) & ~buf_valid & ~redirect;
    assign imem_addr = pc_f;

    // Request FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ISSUE;
            pc_f      <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_valid <= 1'b0;
            instrD    <= NOP_INSTR;
            pcplus4D  <= '0;
            validD    <= 1'b0;
        end else if (redirect) begin
            pc_f      <= target;
            buf_valid <= 1'b0;
            instrD    <= NOP_INSTR;
            validD    <= 1'b0;
            // An outstanding request must still drain before a new one is issued.
            if (state == S_ISSUE) begin
                state <= S_ISSUE;
            end else begin
                state <= imem_ready ? S_ISSUE : S_DISCARD;
            end
        end else begin
            case (state)
                S_ISSUE:   if (imem_req) state <= S_WAIT;
                S_WAIT:    if (imem_ready) state <= S_ISSUE;
                S_DISCARD: if (imem_ready) state <= S_ISSUE;
                default:   state <= S_ISSUE;
            endcase

            if (~stallD) begin
                if (avail) begin
                    instrD    <= data;
                    pcplus4D  <= pc_plus4;
                    validD    <= 1'b1;
                    buf_valid <= 1'b0;
                    if (~stallF) begin
                        pc_f <= pc_plus4;
                    end
                end else begin
                    instrD <= NOP_INSTR;
                    validD <= 1'b0;
                end
            end else if (live) begin
                buf_instr <= imem_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory with programmable
// latency, an expected-PC model feeding a scoreboard, and directed scenarios.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        stallD;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic        jumpD;
    logic [31:0] pcjumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    int          lat;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stallF     (stallF),
        .stallD     (stallD),
        .pcsrcD     (pcsrcD),
        .pcbranchD  (pcbranchD),
        .jumpD      (jumpD),
        .pcjumpD    (pcjumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: the low address half tagged with a fixed opcode pattern.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {16'h8C01, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_redirect(input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt);
        pcsrcD    = br;
        pcbranchD = bt;
        jumpD     = jp;
        pcjumpD   = jt;
    endtask

    task automatic set_stall(input logic s);
        stallD = s;
        stallF = s;
    endtask

    task automatic do_reset(input int l);
        @(posedge clk);
        #2;
        reset = 1'b1;
        set_stall(1'b0);
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        lat = l;
        sb.delete();
        exp_pc = 32'h0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (validD) break;
        end
        check(tag, 32'(validD), 32'd1);
    endtask

    // Memory model: accepts a request, answers after 'lat' cycles, and
    // pushes the architecturally expected instruction onto the scoreboard.
    logic        busy;
    int          cnt;
    logic [31:0] maddr;
    initial begin
        logic        req_s;
        logic [31:0] addr_s;
        busy       = 1'b0;
        cnt        = 0;
        maddr      = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            #1;
            imem_ready = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (req_s) begin
                    check("one_outstanding", 32'(busy), 32'd0);
                    check("req_addr", addr_s, exp_pc);
                    sb.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    busy   = 1'b1;
                    cnt    = lat;
                    maddr  = addr_s;
                end
                if (busy) begin
                    cnt--;
                    if (cnt <= 0) begin
                        imem_ready = 1'b1;
                        imem_rdata = fmem(maddr);
                        busy       = 1'b0;
                    end
                end
            end
        end
    end

    // Decode-side monitor: compares every newly loaded instruction and
    // squashes in-flight expectations when a redirect is accepted.
    logic        new_prev = 1'b0;
    logic [31:0] e_pc;
    always @(negedge clk) begin
        if (reset) begin
            new_prev = 1'b0;
        end else begin
            if (new_prev && validD) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e_pc = sb.pop_front();
                    check("sb_instrD", instrD, fmem(e_pc));
                    check("sb_pcplus4D", pcplus4D, e_pc + 32'd4);
                end
            end
            if (!stallD && (pcsrcD || jumpD)) begin
                sb.delete();
                exp_pc = pcsrcD ? pcbranchD : pcjumpD;
            end
            new_prev = !stallD;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        lat   = 1;
        exp_pc = 32'h0;
        set_stall(1'b0);
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset values
        @(negedge clk);
        check("rst_instrD", instrD, 32'h0);
        check("rst_pcplus4D", pcplus4D, 32'h0);
        check("rst_validD", 32'(validD), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // 1: one-cycle memory, no stalls: issue every other cycle
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_req", 32'(imem_req), 32'((i % 2) == 0));
            if ((i % 2) == 0) check("t1_addr", imem_addr, 32'(4 * (i / 2)));
            check("t1_validD", 32'(validD), 32'((i >= 2) && ((i % 2) == 0)));
        end

        // 2: response lands during a 3-cycle decode stall
        do_reset(1);
        repeat (3) step();
        set_stall(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_no_req", 32'(imem_req), 32'd0);
            check("t2_bubble_held", 32'(validD), 32'd0);
            step();
        end
        set_stall(1'b0);
        step();
        @(negedge clk);
        check("t2_instrD", instrD, 32'h8C01_0004);
        check("t2_pcplus4D", pcplus4D, 32'd8);
        check("t2_validD", 32'(validD), 32'd1);

        // 3: branch while a 3-cycle request is outstanding
        do_reset(3);
        step();
        set_redirect(1'b1, 32'h40, 1'b0, 32'h0);
        step();
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t3_bubble", 32'(validD), 32'd0);
        check("t3_no_req_c2", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        check("t3_no_req_c3", 32'(imem_req), 32'd0);
        check("t3_drop", 32'(validD), 32'd0);
        step();
        @(negedge clk);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr", imem_addr, 32'h40);
        check("t3_no_stale", 32'(validD), 32'd0);
        wait_valid("t3_timeout", 10);
        check("t3_instrD", instrD, 32'h8C01_0040);
        check("t3_pcplus4D", pcplus4D, 32'h44);

        // 4: branch held off while decode stalls
        do_reset(1);
        repeat (2) step();
        set_stall(1'b1);
        set_redirect(1'b1, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        check("t4_req_c2", 32'(imem_req), 32'd1);
        check("t4_addr_c2", imem_addr, 32'h4);
        step();
        @(negedge clk);
        check("t4_pc_held_c3", imem_addr, 32'h4);
        step();
        @(negedge clk);
        check("t4_no_req_c4", 32'(imem_req), 32'd0);
        check("t4_pc_held_c4", imem_addr, 32'h4);
        step();
        set_stall(1'b0);
        step();
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h80);
        check("t4_bubble", 32'(validD), 32'd0);

        // 5: branch and jump together, branch wins
        do_reset(1);
        repeat (2) step();
        set_redirect(1'b1, 32'h100, 1'b1, 32'h200);
        step();
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_addr", imem_addr, 32'h100);
        wait_valid("t5_timeout", 10);
        check("t5_pcplus4D", pcplus4D, 32'h104);

        // 6: reset in the middle of a request at pc 0x20
        do_reset(1);
        repeat (4) step();
        lat = 3;
        set_redirect(1'b0, 32'h0, 1'b1, 32'h20);
        step();
        set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_addr", imem_addr, 32'h20);
        step();
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_instrD", instrD, 32'h0);
        check("t6_rst_pcplus4D", pcplus4D, 32'h0);
        check("t6_rst_validD", 32'(validD), 32'd0);
        check("t6_rst_addr", imem_addr, 32'h0);
        sb.delete();
        exp_pc = 32'h0;
        lat    = 1;
        repeat (2) step();
        reset      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t6_first_req", 32'(imem_req), 32'd1);
        check("t6_first_addr", imem_addr, 32'h0);
        check("t6_stray_ignored", 32'(validD), 32'd0);
        wait_valid("t6_timeout", 10);
        check("t6_instrD", instrD, 32'h8C01_0000);
        check("t6_pcplus4D", pcplus4D, 32'h4);

        repeat (2) @(negedge clk);
        check("sb_final", 32'(sb.size() <= 1), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
